// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle RV32 core (lw, sw, add/sub/and/or, beq).
// Moore decode per state plus Mealy fetch strobes gated by mem_ready; counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [1:0]       ALUOp,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             pc_source,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             rdy;
  logic             retire;
  logic             unused_zero;

  // Branch resolution happens in the datapath via pc_write_cond; the FSM never looks at zero.
  assign unused_zero = zero;

  // Masking with rst_n keeps the fetch strobes low for the whole reset window.
  assign rdy = mem_ready & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    instret_d     = instret_q;
    retire        = 1'b0;
    ALUOp         = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    illegal       = 1'b0;
    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = rdy;
        pc_write  = rdy;
        if (rdy) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'b10;
        case (opcode)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXEC;
          OP_BR:        state_d = BRANCH;
          default:      state_d = TRAP;
        endcase
      end
      MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (rdy) state_d = MEMWB;
      end
      MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      EXEC: begin
        alu_src_a = 1'b1;
        ALUOp     = 2'b10;
        state_d   = ALUWB;
      end
      ALUWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
      default: state_d = FETCH;
    endcase
    if (retire) instret_d = instret_q + CNT_W'(1);
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: directed instruction sequences push expected
// per-cycle control words; a negedge monitor pops and compares against the DUT outputs.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [1:0]  ALUOp;
  logic        pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write;
  logic        ir_write, mem_to_reg, reg_write, alu_src_a;
  logic [1:0]  alu_src_b;
  logic [3:0]  state;
  logic        illegal;
  logic [31:0] instret;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .ALUOp(ALUOp), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .state(state), .illegal(illegal),
    .instret(instret)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_I  = 7'b0010011;

  // Control word: {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
  //                ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b[1:0]}
  localparam logic [11:0] C_FR  = 12'b1000_1010_0001;
  localparam logic [11:0] C_FW  = 12'b0000_1000_0001;
  localparam logic [11:0] C_DEC = 12'b0000_0000_0010;
  localparam logic [11:0] C_MA  = 12'b0000_0000_0110;
  localparam logic [11:0] C_MRD = 12'b0001_1000_0000;
  localparam logic [11:0] C_MWB = 12'b0000_0001_1000;
  localparam logic [11:0] C_MWR = 12'b0001_0100_0000;
  localparam logic [11:0] C_EX  = 12'b0000_0000_0100;
  localparam logic [11:0] C_AWB = 12'b0000_0000_1000;
  localparam logic [11:0] C_BR  = 12'b0110_0000_0100;
  localparam logic [11:0] C_NON = 12'b0000_0000_0000;

  typedef struct {
    logic [3:0]  st;
    logic [11:0] c;
    logic [1:0]  aop;
    logic        ill;
    logic [31:0] ir;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad   = 0;
  int          nstep = 0;
  logic [31:0] exp_ir = 0;

  always @(negedge clk) begin
    exp_t        e;
    logic [11:0] gc;
    if (q.size() > 0) begin
      e  = q.pop_front();
      gc = {pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
            ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b};
      total++;
      if (state !== e.st || gc !== e.c || ALUOp !== e.aop || illegal !== e.ill ||
          instret !== e.ir) begin
        bad++;
        $display("FAIL step%0d: got st=%0d ctl=%b aop=%b ill=%b ir=%0d, want st=%0d ctl=%b aop=%b ill=%b ir=%0d",
                 e.id, state, gc, ALUOp, illegal, instret, e.st, e.c, e.aop, e.ill, e.ir);
      end
    end
  end

  task automatic push(input logic [3:0] st, input logic [11:0] c, input logic [1:0] aop);
    exp_t e;
    e.st  = st;
    e.c   = c;
    e.aop = aop;
    e.ill = (st == 4'd15);
    e.ir  = exp_ir;
    e.id  = nstep;
    nstep++;
    q.push_back(e);
  endtask

  // Called just after a rising edge: drive inputs, post the expectation for this cycle.
  task automatic cyc(input logic [6:0] op, input logic z, input logic rdy,
                     input logic [3:0] st, input logic [11:0] c, input logic [1:0] aop,
                     input bit inc);
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    push(st, c, aop);
    if (inc) exp_ir++;
    @(posedge clk);
    #1;
  endtask

  // Reset dropped between clock edges; mem_ready high to show the strobes stay masked.
  task automatic async_reset();
    mem_ready = 1'b1;
    #2;
    rst_n  = 1'b0;
    exp_ir = 0;
    push(4'd0, C_FW, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic rtype();
    cyc(OP_R, 0, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_R, 0, 1, 4'd1, C_DEC, 2'b00, 0);
    cyc(OP_R, 0, 1, 4'd6, C_EX,  2'b10, 0);
    cyc(OP_R, 0, 1, 4'd7, C_AWB, 2'b00, 1);
  endtask

  task automatic beq(input logic z);
    cyc(OP_BR, z, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_BR, z, 1, 4'd1, C_DEC, 2'b00, 0);
    cyc(OP_BR, z, 1, 4'd8, C_BR,  2'b01, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = OP_R;
    zero      = 1'b0;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    push(4'd0, C_FW, 2'b00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    rtype();

    // lw: FETCH stalls 2 cycles, MEMRD stalls 3 cycles
    cyc(OP_LW, 0, 0, 4'd0, C_FW,  2'b00, 0);
    cyc(OP_LW, 0, 0, 4'd0, C_FW,  2'b00, 0);
    cyc(OP_LW, 0, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_LW, 0, 1, 4'd1, C_DEC, 2'b00, 0);
    cyc(OP_LW, 0, 1, 4'd2, C_MA,  2'b00, 0);
    cyc(OP_LW, 0, 0, 4'd3, C_MRD, 2'b00, 0);
    cyc(OP_LW, 0, 0, 4'd3, C_MRD, 2'b00, 0);
    cyc(OP_LW, 0, 0, 4'd3, C_MRD, 2'b00, 0);
    cyc(OP_LW, 0, 1, 4'd3, C_MRD, 2'b00, 0);
    cyc(OP_LW, 0, 1, 4'd4, C_MWB, 2'b00, 1);

    beq(1'b1);
    beq(1'b0);

    cyc(OP_SW, 0, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_SW, 0, 1, 4'd1, C_DEC, 2'b00, 0);
    cyc(OP_SW, 0, 1, 4'd2, C_MA,  2'b00, 0);
    cyc(OP_SW, 0, 1, 4'd5, C_MWR, 2'b00, 1);

    // sw abandoned by an asynchronous reset while waiting in MEMWR
    cyc(OP_SW, 0, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_SW, 0, 1, 4'd1, C_DEC, 2'b00, 0);
    cyc(OP_SW, 0, 1, 4'd2, C_MA,  2'b00, 0);
    cyc(OP_SW, 0, 0, 4'd5, C_MWR, 2'b00, 0);
    opcode = OP_SW;
    async_reset();

    rtype();

    // illegal opcode traps and holds with everything frozen
    cyc(OP_I, 0, 1, 4'd0, C_FR,  2'b00, 0);
    cyc(OP_I, 0, 1, 4'd1, C_DEC, 2'b00, 0);
    for (int i = 0; i < 20; i++) cyc(OP_SW, 0, 1, 4'd15, C_NON, 2'b00, 0);
    async_reset();
    rtype();

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending checks, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
